sensor_monitor_ctrl: RTL

Sequencing controller that sits around the four-input sensor error detector. It paces sampling of `sensors[3:0]` with a programmable divider and qualifies low-priority faults over consecutive samples; critical faults bypass qualification. It latches a coded alarm until software acknowledges it and counts alarm events. The block is a fully synchronous FSM plus counters and feeds the system status/interrupt logic.

---
 rtl/sensor_monitor_ctrl.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/sensor_monitor_ctrl.sv
// Sensor monitor sequencer: paces sampling with a divider, qualifies low-priority
// faults over consecutive samples, latches a coded alarm until acknowledged.
module sensor_monitor_ctrl #(
   parameter int SAMPLE_DIV  = 4,
   parameter int CONFIRM_CNT = 3,
   parameter int CNT_WIDTH   = 8
) (
   input  logic                 clk,
   input  logic                 n_rst,
   input  logic                 enable,
   input  logic [3:0]           sensors,
   input  logic                 clear,
   output logic                 sample_strobe,
   output logic                 alarm,
   output logic [1:0]           alarm_code,
   output logic [CNT_WIDTH-1:0] event_count
);

   localparam int DIV_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam int CONF_W = $clog2(CONFIRM_CNT + 1);

   localparam logic [1:0] CODE_NONE = 2'b00;
   localparam logic [1:0] CODE_LOW  = 2'b01;
   localparam logic [1:0] CODE_CRIT = 2'b10;

   typedef enum logic [2:0] {
      IDLE,
      MONITOR,
      CONFIRM,
      ALARM,
      WAIT_CLEAN
   } state_t;

   state_t                state_q, state_d;
   logic [DIV_W-1:0]      div_q, div_d;
   logic [CONF_W-1:0]     conf_q, conf_d;
   logic [CONF_W-1:0]     conf_inc;
   logic                  alarm_q, alarm_d;
   logic [1:0]            code_q, code_d;
   logic [CNT_WIDTH-1:0]  event_q;
   logic                  enter_alarm;
   logic                  tick, crit, low;

   assign tick     = enable && (div_q == DIV_W'(SAMPLE_DIV - 1));
   assign crit     = sensors[0];
   assign low      = sensors[1] & (sensors[2] | sensors[3]) & ~crit;
   assign conf_inc = conf_q + CONF_W'(1);

   always_comb begin
      if (!enable || tick) div_d = '0;
      else                 div_d = div_q + DIV_W'(1);
   end

   always_comb begin
      state_d     = state_q;
      conf_d      = conf_q;
      alarm_d     = alarm_q;
      code_d      = code_q;
      enter_alarm = 1'b0;
      case (state_q)
         IDLE: begin
            conf_d = '0;
            if (enable) state_d = MONITOR;
         end
         MONITOR: begin
            if (!enable) begin
               state_d = IDLE;
               conf_d  = '0;
            end else if (tick) begin
               if (crit) begin
                  state_d = ALARM; alarm_d = 1'b1; code_d = CODE_CRIT; enter_alarm = 1'b1;
               end else if (low) begin
                  if (CONFIRM_CNT == 1) begin
                     state_d = ALARM; alarm_d = 1'b1; code_d = CODE_LOW; enter_alarm = 1'b1;
                  end else begin
                     state_d = CONFIRM;
                     conf_d  = CONF_W'(1);
                  end
               end
            end
         end
         CONFIRM: begin
            if (!enable) begin
               state_d = IDLE;
               conf_d  = '0;
            end else if (tick) begin
               conf_d = '0;
               if (crit) begin
                  state_d = ALARM; alarm_d = 1'b1; code_d = CODE_CRIT; enter_alarm = 1'b1;
               end else if (low) begin
                  if (conf_inc == CONF_W'(CONFIRM_CNT)) begin
                     state_d = ALARM; alarm_d = 1'b1; code_d = CODE_LOW; enter_alarm = 1'b1;
                  end else begin
                     conf_d = conf_inc;
                  end
               end else begin
                  state_d = MONITOR;
               end
            end
         end
         ALARM: begin
            // Acknowledge beats a coincident critical sample; the upgrade is not a new event.
            if (clear) begin
               state_d = WAIT_CLEAN; alarm_d = 1'b0; code_d = CODE_NONE;
            end else if (tick && crit && code_q == CODE_LOW) begin
               code_d = CODE_CRIT;
            end
         end
         WAIT_CLEAN: begin
            if (!enable) begin
               state_d = IDLE;
            end else if (tick) begin
               if (crit) begin
                  state_d = ALARM; alarm_d = 1'b1; code_d = CODE_CRIT; enter_alarm = 1'b1;
               end else if (!low) begin
                  state_d = MONITOR;
               end
            end
         end
         default: begin
            state_d = IDLE;
            conf_d  = '0;
            alarm_d = 1'b0;
            code_d  = CODE_NONE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q <= IDLE;
         div_q   <= '0;
         conf_q  <= '0;
         alarm_q <= 1'b0;
         code_q  <= CODE_NONE;
         event_q <= '0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         conf_q  <= conf_d;
         alarm_q <= alarm_d;
         code_q  <= code_d;
         if (enter_alarm && event_q != {CNT_WIDTH{1'b1}}) event_q <= event_q + CNT_WIDTH'(1);
      end
   end

   assign sample_strobe = tick;
   assign alarm         = alarm_q;
   assign alarm_code    = code_q;
   assign event_count   = event_q;

endmodule
